// File: rtl/cpu_writeback.sv
// Writeback stage of the stack CPU: commits pop/push to the operand stack,
// registers the top two entries, drives the fetch redirect and latches faults.
module cpu_writeback #(
  parameter int STACK_DEPTH = 1024,
  parameter int PTR_W       = 11
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [2:0]  c__to_push_4a,
  input  logic [10:0] st__to_pop_4a,
  input  logic [34:0] st__to_push_4a,
  input  logic        kill_4a,
  input  logic [31:0] branch_target_4a,
  input  logic [31:0] pc_4a,
  output logic        redirect_5a,
  output logic [31:0] redirect_pc_5a,
  output logic [34:0] st__top0_5a,
  output logic [34:0] st__top1_5a,
  output logic [10:0] st__depth_5a,
  output logic        fault_5a,
  output logic [1:0]  fault_code_5a,
  output logic [31:0] fault_pc_5a,
  output logic [31:0] retired_5a
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_EXT = (PTR_W + 1)'(STACK_DEPTH);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  state_t state_reg, state_next;

  logic [34:0]      mem [STACK_DEPTH];
  logic [PTR_W-1:0] sp_reg;
  logic [34:0]      top0_reg, top1_reg;
  logic             redirect_reg;
  logic [31:0]      redirect_pc_reg;
  logic             fault_reg;
  logic [1:0]       fault_code_reg;
  logic [31:0]      fault_pc_reg;
  logic [31:0]      retired_reg;

  logic             push;
  logic [PTR_W:0]   sp_ext, pop_ext, mid, sp_next;
  logic             underflow, overflow;
  logic             fault_now, commit;
  logic [PTR_W:0]   rd0_ptr, rd1_ptr;
  logic [34:0]      top0_next, top1_next;

  // Pointer math is one bit wider than the depth so mid + push never wraps.
  always_comb begin
    push      = (c__to_push_4a != 3'd0);
    sp_ext    = {1'b0, sp_reg};
    pop_ext   = (PTR_W + 1)'(st__to_pop_4a);
    mid       = sp_ext - pop_ext;
    sp_next   = mid + {{PTR_W{1'b0}}, push};
    underflow = (pop_ext > sp_ext);
    overflow  = !underflow && (sp_next > DEPTH_EXT);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_reg <= S_RUN;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == S_RUN && (underflow || overflow)) state_next = S_FAULT;
  end

  always_comb begin
    fault_now = (state_reg == S_RUN) && (underflow || overflow);
    commit    = (state_reg == S_RUN) && !(underflow || overflow);
  end

  // The freshly pushed value lands at mid, so top0 takes it directly while
  // top1 (one below mid) is never the entry being written this cycle.
  always_comb begin
    rd0_ptr   = sp_next - 1'b1;
    rd1_ptr   = sp_next - 2'd2;
    top0_next = '0;
    top1_next = '0;
    if (push)
      top0_next = st__to_push_4a;
    else if (sp_next >= 1)
      top0_next = mem[rd0_ptr[AW-1:0]];
    if (sp_next >= 2)
      top1_next = mem[rd1_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (commit && push) mem[mid[AW-1:0]] <= st__to_push_4a;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sp_reg          <= '0;
      top0_reg        <= '0;
      top1_reg        <= '0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
      fault_reg       <= 1'b0;
      fault_code_reg  <= 2'd0;
      fault_pc_reg    <= '0;
      retired_reg     <= '0;
    end else begin
      redirect_reg <= 1'b0;
      if (commit) begin
        sp_reg       <= sp_next[PTR_W-1:0];
        top0_reg     <= top0_next;
        top1_reg     <= top1_next;
        retired_reg  <= retired_reg + 32'd1;
        redirect_reg <= kill_4a;
        if (kill_4a) redirect_pc_reg <= branch_target_4a;
      end
      if (fault_now) begin
        fault_reg      <= 1'b1;
        fault_code_reg <= underflow ? 2'd1 : 2'd2;
        fault_pc_reg   <= pc_4a;
      end
    end
  end

  assign redirect_5a    = redirect_reg;
  assign redirect_pc_5a = redirect_pc_reg;
  assign st__top0_5a    = top0_reg;
  assign st__top1_5a    = top1_reg;
  assign st__depth_5a   = 11'(sp_reg);
  assign fault_5a       = fault_reg;
  assign fault_code_5a  = fault_code_reg;
  assign fault_pc_5a    = fault_pc_reg;
  assign retired_5a     = retired_reg;

endmodule
